// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: upstream valid/ready with flattened channels,
// downstream valid/ready with the selected word and its channel index.
interface mux_n_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;

    modport master (
        output in_valid, sel, data_in, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, sel, data_in, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_n_pipe.sv
// Registered N-input word selector with valid/ready handshake and a 2-entry
// skid buffer (main register drives the outputs, skid absorbs one stall).
module mux_n_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    mux_n_pipe_if.slave  bus,
    output logic         sel_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Out-of-range indices match no channel and therefore yield an all-zero word.
    function automatic logic [WIDTH-1:0] select_word(
        input logic [NUM_IN*WIDTH-1:0] words,
        input logic [SEL_W-1:0]        idx
    );
        logic [WIDTH-1:0] result;
        result = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (idx == SEL_W'(k)) begin
                result = words[k*WIDTH +: WIDTH];
            end
        end
        return result;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [WIDTH-1:0]  main_data_r;
    logic [SEL_W-1:0]  main_sel_r;
    logic [WIDTH-1:0]  skid_data_r;
    logic [SEL_W-1:0]  skid_sel_r;
    logic              sel_err_r;

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              sel_oor_s;
    logic [WIDTH-1:0]  capture_data_s;
    logic              load_main_s;
    logic              load_skid_s;
    logic              move_skid_s;

    assign in_xfer_s      = bus.in_valid && in_ready_r;
    assign out_xfer_s     = out_valid_r && bus.out_ready;
    assign sel_oor_s      = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_IN));
    assign capture_data_s = select_word(bus.data_in, bus.sel);

    assign bus.out_valid  = out_valid_r;
    assign bus.in_ready   = in_ready_r;
    assign bus.out_data   = main_data_r;
    assign bus.out_sel    = main_sel_r;
    assign sel_err        = sel_err_r;

    // Next-state and storage-steering decode; flush overrides every transfer.
    always_comb begin
        state_nxt_s = state_r;
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_nxt_s = ST_ONE;
                    load_main_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    state_nxt_s = ST_ONE;
                    load_main_s = 1'b1;
                end else if (in_xfer_s) begin
                    state_nxt_s = ST_TWO;
                    load_skid_s = 1'b1;
                end else if (out_xfer_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (out_xfer_s) begin
                    state_nxt_s = ST_ONE;
                    move_skid_s = 1'b1;
                end else begin
                    state_nxt_s = ST_TWO;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            load_main_s = 1'b0;
            load_skid_s = 1'b0;
            move_skid_s = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, handshake flags and word storage; data registers hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            main_data_r <= {WIDTH{1'b0}};
            main_sel_r  <= {SEL_W{1'b0}};
            skid_data_r <= {WIDTH{1'b0}};
            skid_sel_r  <= {SEL_W{1'b0}};
            sel_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            in_ready_r  <= (state_nxt_s != ST_TWO);
            if (load_main_s) begin
                main_data_r <= capture_data_s;
                main_sel_r  <= bus.sel;
            end else if (move_skid_s) begin
                main_data_r <= skid_data_r;
                main_sel_r  <= skid_sel_r;
            end
            if (load_skid_s) begin
                skid_data_r <= capture_data_s;
                skid_sel_r  <= bus.sel;
            end
            // A flushed transfer is discarded, so it cannot raise the error.
            if (in_xfer_s && sel_oor_s && !flush) begin
                sel_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-input, registered word selector with a valid/ready handshake and a 2-entry skid buffer. It generalises the CPU's 32-bit 2:1 `Mux2` to any width and channel count. It adds one cycle of registration so it can sit between pipeline stages, for example as the ALU-operand or writeback-source select. It also supports back-pressure and flush, so a stall or branch squash never drops or duplicates a selected word.

## Interface
- `WIDTH`, 32: data word width in bits.
- `NUM_IN`, 4: number of input channels, ≥2.
- `SEL_W`, `$clog2(NUM_IN)`: select width. It is derived and must not be overridden.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `flush` input, 1 bit: synchronous squash of all buffered words.
- `in_valid` input, 1 bit: the upstream word is presented.
- `in_ready` output, 1 bit: the block can accept a word this cycle.
- `sel` input, `SEL_W` bits: channel index, sampled on an accepted transfer.
- `data_in` input, `NUM_IN*WIDTH` bits: flattened channels. Channel k is `data_in[k*WIDTH +: WIDTH]`.
- `out_valid` output, 1 bit: `out_data` holds a valid word.
- `out_ready` input, 1 bit: downstream accepts `out_data` this cycle.
- `out_data` output, `WIDTH` bits: the selected word.
- `out_sel` output, `SEL_W` bits: the channel index that produced `out_data`.
- `sel_err` output, 1 bit: sticky flag set when an accepted `sel` is ≥ `NUM_IN`.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Selection happens at accept time. The word `data_in[sel]` and `sel` are captured together.
- Out-of-range `sel` (possible only when `NUM_IN` is not a power of two):
  - The captured word is all-zero.
  - `out_sel` carries the raw `sel` value.
  - `sel_err` is set. It is cleared only by `reset`.
- Storage consists of a main register (drives the outputs) and a skid register.
- State machine:
  - EMPTY: nothing held. `out_valid`=0, `in_ready`=1. On input transfer, go to ONE.
  - ONE: main register holds a word. `out_valid`=1, `in_ready`=1.
    - Input transfer with output transfer: main register is replaced, stay in ONE.
    - Input transfer without output transfer: word goes to the skid register, go to TWO.
    - Output transfer only: go to EMPTY.
  - TWO: both registers full. `out_valid`=1, `in_ready`=0.
    - On output transfer, skid moves to main, go to ONE.
- `in_ready` is driven from a register (the negation of skid-full). It never depends combinationally on `out_ready`.
- Ordering is strict FIFO. A word is never reordered, duplicated or lost.
- `flush`:
  - Go to EMPTY next cycle.
  - Any input transfer in the same cycle is discarded.
  - Any output transfer in the same cycle still completes from the downstream point of view.
  - `sel_err` is unaffected.
- `reset` has priority over `flush`. Asserting it mid-transfer discards every held word.

## Timing
- Latency is 1 cycle. A word accepted at edge n is on `out_data` with `out_valid`=1 after edge n.
- Sustained throughput is 1 word/cycle while `out_ready`=1.
- A single-cycle `out_ready`=0 stall causes no bubble. The skid register absorbs the word.
- `in_ready` deasserts the cycle after the skid register fills. It reasserts the cycle after the skid register drains.
- Reset values after the first edge with `reset`=1:
  - `out_valid`=0, `in_ready`=1.
  - `out_data`=0, `out_sel`=0, `sel_err`=0.
  - State is EMPTY.
- While `out_valid`=0, `out_data` and `out_sel` hold their last value. They are 0 after reset.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_sel` are stable.

## Test plan
- Basic select (`NUM_IN`=4, `out_ready`=1):
  - Stimulus: ch0=0x00000001, ch1=0x00000002, ch2=0x0000000A, ch3=0xFFFFFFFF. Accept `sel`=0,1,2,3 on consecutive cycles.
  - Response: `out_data` is 0x1, 0x2, 0xA, 0xFFFFFFFF one cycle later, with `out_sel` 0..3.
- Back-pressure:
  - Stimulus: `out_ready`=0 for 3 cycles while `in_valid`=1 streams words W0, W1, W2.
  - Response: W0 stays on the output. `in_ready` drops after W1 is accepted. W2 is held upstream. After `out_ready`=1, the outputs are W0, W1, W2 in order with no gaps.
- Flush:
  - Stimulus: state TWO holding 0x1 and 0x2. Assert `flush` with `in_valid`=1 and `sel`=3.
  - Response: next cycle `out_valid`=0 and `in_ready`=1. The 0xFFFFFFFF word is never output.
- Out-of-range select (`NUM_IN`=3):
  - Stimulus: accept `sel`=3.
  - Response: `out_data`=0, `out_sel`=3, `sel_err`=1. `sel_err` stays 1 across later valid transfers and across `flush`.
- Reset mid-operation:
  - Stimulus: assert `reset` in state TWO with `in_valid`=1.
  - Response: after the edge, `out_valid`=0, `in_ready`=1, `out_data`=0, `sel_err`=0. No held word reappears.
- Randomised handshake, 1000 cycles, random `in_valid`, `out_ready` and `sel`:
  - Response: the output sequence equals a reference-model FIFO of selected words. At most 2 words are ever in flight.
